lamp_code_controller: RTL and testbench

Lamp-code lock controller built around the one-hot lamp sequence detector datapath. It holds a programmable sequence of lamp codes, one code per position, and scores each complete entry attempt. A correct attempt produces an unlock pulse. Consecutive failed attempts are counted, and reaching the fail limit escalates to an acknowledged alarm followed by a timed lockout. It sits between the lamp input source and the alarm and indicator outputs.

---
 rtl/lamp_code_pkg.sv | 14 +
 rtl/lamp_code_regfile.sv | 23 ++
 rtl/lamp_code_controller.sv | 128 ++++++++++++
 tb/tb_lamp_code_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lamp_code_pkg.sv
// lamp_code_pkg: shared states, lamp codes and helpers for the lamp-code lock.
package lamp_code_pkg;
   typedef enum logic [1:0] {IDLE, ENTRY, ALARM, LOCKOUT} state_t;
   localparam logic [2:0] LAMP1 = 3'b001;
   localparam logic [2:0] LAMP2 = 3'b010;
   localparam logic [2:0] LAMP3 = 3'b100;
   function automatic logic is_onehot(logic [2:0] v);
      return v == LAMP1 || v == LAMP2 || v == LAMP3;
   endfunction
   // Reset code cycles lamp1, lamp2, lamp3, lamp1, ...
   function automatic logic [2:0] default_code(int i);
      return (i % 3 == 0) ? LAMP1 : (i % 3 == 1) ? LAMP2 : LAMP3;
   endfunction
endpackage

// File: rtl/lamp_code_regfile.sv
// lamp_code_regfile: programmable code storage, one one-hot lamp code per position.
module lamp_code_regfile import lamp_code_pkg::*; #(
   parameter int SEQ_LEN = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       we,
   input  logic [2:0] idx,
   input  logic [2:0] wdata,
   input  logic [2:0] ridx,
   output logic [2:0] rdata
);
   localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   logic [2:0] code [SEQ_LEN];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SEQ_LEN; i++) code[i] <= default_code(i);
      end else if (we && 32'(idx) < SEQ_LEN && is_onehot(wdata)) begin
         code[idx[IW-1:0]] <= wdata;
      end
   end
   assign rdata = (32'(ridx) < SEQ_LEN) ? code[ridx[IW-1:0]] : 3'b000;
endmodule

// File: rtl/lamp_code_controller.sv
// lamp_code_controller: scores lamp-code attempts, counts failures, escalates to
// an acknowledged alarm followed by a timed lockout.
module lamp_code_controller import lamp_code_pkg::*; #(
   parameter int SEQ_LEN     = 3,
   parameter int MAX_FAILS   = 3,
   parameter int ALARM_HOLD  = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int TIMEOUT     = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lamp_valid,
   input  logic [2:0] lampadas,
   input  logic       cfg_we,
   input  logic [2:0] cfg_idx,
   input  logic [2:0] cfg_code,
   input  logic       alarm_ack,
   output logic       alarme,
   output logic       unlocked,
   output logic       locked_out,
   output logic       busy,
   output logic [3:0] fail_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int HW = $clog2(ALARM_HOLD + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   state_t          state, nstate;
   logic [2:0]      pos, npos, code_q;
   logic            mis, nmis, miss, accept, last, hold_done, cfg_ok;
   logic            ack_seen, nack, nunl;
   logic [3:0]      nfail;
   logic [TW-1:0]   tcnt, ntcnt;
   logic [HW-1:0]   hold_cnt, nhold;
   logic [LW-1:0]   lock_cnt, nlock;
   assign accept    = lamp_valid && (state == IDLE || state == ENTRY);
   assign last      = pos == 3'(SEQ_LEN - 1);
   assign miss      = (state == ENTRY && mis) || !is_onehot(lampadas) || lampadas != code_q;
   assign hold_done = hold_cnt == HW'(ALARM_HOLD - 1);
   assign cfg_ok    = cfg_we && state == IDLE && !lamp_valid;
   lamp_code_regfile #(.SEQ_LEN(SEQ_LEN)) u_regfile (
      .clk(clk), .reset_n(reset_n), .we(cfg_ok), .idx(cfg_idx), .wdata(cfg_code),
      .ridx(pos), .rdata(code_q)
   );
   always_comb begin
      nstate = state;
      npos   = pos;
      nmis   = mis;
      nfail  = fail_count;
      ntcnt  = tcnt;
      nhold  = hold_cnt;
      nlock  = lock_cnt;
      nack   = ack_seen;
      nunl   = 1'b0;
      case (state)
         IDLE, ENTRY: begin
            if (accept && last) begin
               npos   = '0;
               nmis   = 1'b0;
               ntcnt  = '0;
               nunl   = !miss;
               nfail  = miss ? fail_count + 4'd1 : 4'd0;
               nstate = (miss && nfail == 4'(MAX_FAILS)) ? ALARM : IDLE;
            end else if (accept) begin
               npos   = pos + 3'd1;
               nmis   = miss;
               ntcnt  = '0;
               nstate = ENTRY;
            end else if (state == ENTRY) begin
               ntcnt = tcnt + TW'(1);
               if (tcnt == TW'(TIMEOUT - 1)) begin
                  nstate = IDLE;
                  npos   = '0;
                  nmis   = 1'b0;
                  ntcnt  = '0;
               end
            end
         end
         ALARM: begin
            nack  = ack_seen || alarm_ack;
            nhold = hold_done ? hold_cnt : hold_cnt + HW'(1);
            if (hold_done && nack) begin
               nstate = LOCKOUT;
               nfail  = 4'd0;
               nhold  = '0;
               nack   = 1'b0;
            end
         end
         LOCKOUT: begin
            nlock = lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
               nstate = IDLE;
               nlock  = '0;
            end
         end
         default: nstate = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pos        <= '0;
         mis        <= 1'b0;
         fail_count <= '0;
         tcnt       <= '0;
         hold_cnt   <= '0;
         lock_cnt   <= '0;
         ack_seen   <= 1'b0;
         alarme     <= 1'b0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= nstate;
         pos        <= npos;
         mis        <= nmis;
         fail_count <= nfail;
         tcnt       <= ntcnt;
         hold_cnt   <= nhold;
         lock_cnt   <= nlock;
         ack_seen   <= nack;
         alarme     <= nstate == ALARM;
         unlocked   <= nunl;
         locked_out <= nstate == LOCKOUT;
         busy       <= nstate != IDLE;
      end
   end
endmodule

// File: tb/tb_lamp_code_controller.sv
// tb_lamp_code_controller: directed scenarios with a scoreboard of expected attempt outcomes.
module tb_lamp_code_controller;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       lamp_valid, cfg_we, alarm_ack;
   logic [2:0] lampadas, cfg_idx, cfg_code;
   logic       alarme, unlocked, locked_out, busy;
   logic [3:0] fail_count;
   typedef struct {logic unl; logic alm; logic [3:0] fc;} exp_t;
   exp_t       sb[$];
   logic [2:0] mcode [3];
   int         mfail;
   int         compared = 0;
   int         mismatched = 0;
   int         n, m;
   lamp_code_controller dut (
      .clk(clk), .reset_n(reset_n), .lamp_valid(lamp_valid), .lampadas(lampadas),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code), .alarm_ack(alarm_ack),
      .alarme(alarme), .unlocked(unlocked), .locked_out(locked_out), .busy(busy),
      .fail_count(fail_count)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      mcode[0] = 3'b001;
      mcode[1] = 3'b010;
      mcode[2] = 3'b100;
      mfail = 0;
   endtask
   task automatic push_exp(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2);
      exp_t e;
      if (s0 == mcode[0] && s1 == mcode[1] && s2 == mcode[2]) begin
         mfail = 0;
         e.unl = 1'b1;
         e.alm = 1'b0;
      end else begin
         mfail++;
         e.unl = 1'b0;
         e.alm = (mfail == 3);
      end
      e.fc = 4'(mfail);
      sb.push_back(e);
   endtask
   task automatic pop_check(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, ".unlocked"}, 32'(unlocked), 32'(e.unl));
      chk({tag, ".alarme"}, 32'(alarme), 32'(e.alm));
      chk({tag, ".fail_count"}, 32'(fail_count), 32'(e.fc));
   endtask
   task automatic sym(input logic [2:0] s);
      lamp_valid = 1'b1;
      lampadas = s;
      tick();
   endtask
   task automatic attempt(input string tag, input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2);
      push_exp(s0, s1, s2);
      sym(s0);
      sym(s1);
      sym(s2);
      lamp_valid = 1'b0;
      lampadas = 3'b000;
      pop_check(tag);
   endtask
   task automatic cfg(input logic [2:0] idx, input logic [2:0] code);
      cfg_we = 1'b1;
      cfg_idx = idx;
      cfg_code = code;
      tick();
      cfg_we = 1'b0;
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, ".alarme"}, 32'(alarme), 0);
      chk({tag, ".unlocked"}, 32'(unlocked), 0);
      chk({tag, ".locked_out"}, 32'(locked_out), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".fail_count"}, 32'(fail_count), 0);
   endtask
   initial begin
      reset_n = 1'b0;
      lamp_valid = 1'b0;
      lampadas = 3'b000;
      cfg_we = 1'b0;
      cfg_idx = 3'd0;
      cfg_code = 3'b000;
      alarm_ack = 1'b0;
      model_reset();
      #12;
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();
      attempt("correct", 3'b001, 3'b010, 3'b100);
      tick();
      chk("unlock_one_cycle", 32'(unlocked), 0);
      attempt("fail1", 3'b001, 3'b100, 3'b100);
      attempt("recover", 3'b001, 3'b010, 3'b100);
      sym(3'b001);
      lamp_valid = 1'b0;
      chk("busy_mid_attempt", 32'(busy), 1);
      sym(3'b010);
      push_exp(3'b001, 3'b010, 3'b100);
      sym(3'b100);
      lamp_valid = 1'b0;
      pop_check("gap_attempt");
      attempt("esc1", 3'b010, 3'b010, 3'b010);
      attempt("esc2", 3'b010, 3'b010, 3'b010);
      attempt("esc3", 3'b010, 3'b010, 3'b010);
      lamp_valid = 1'b1;
      lampadas = 3'b001;
      n = 1;
      tick();
      alarm_ack = 1'b1;
      if (alarme) n++;
      tick();
      alarm_ack = 1'b0;
      while (alarme && n < 100) begin
         n++;
         tick();
      end
      chk("alarm_len_early_ack", 32'(n), 8);
      chk("lockout_starts", 32'(locked_out), 1);
      chk("fail_cleared_in_lockout", 32'(fail_count), 0);
      m = 0;
      while (locked_out && m < 100) begin
         m++;
         tick();
      end
      lamp_valid = 1'b0;
      mfail = 0;
      chk("lockout_len", 32'(m), 16);
      chk("idle_after_lockout", 32'(busy), 0);
      chk("fail_after_lockout", 32'(fail_count), 0);
      attempt("after_lockout", 3'b001, 3'b010, 3'b100);
      attempt("late1", 3'b100, 3'b100, 3'b100);
      attempt("late2", 3'b100, 3'b100, 3'b100);
      attempt("late3", 3'b100, 3'b100, 3'b100);
      repeat (20) tick();
      chk("alarm_held_no_ack", 32'(alarme), 1);
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      chk("alarm_drop_late_ack", 32'(alarme), 0);
      chk("lockout_after_late_ack", 32'(locked_out), 1);
      m = 0;
      while (locked_out && m < 100) begin
         m++;
         tick();
      end
      mfail = 0;
      chk("lockout_len_late", 32'(m), 16);
      cfg(3'd0, 3'b100);
      cfg(3'd1, 3'b100);
      cfg(3'd2, 3'b001);
      cfg(3'd3, 3'b010);
      cfg(3'd0, 3'b011);
      mcode[0] = 3'b100;
      mcode[1] = 3'b100;
      mcode[2] = 3'b001;
      attempt("new_code", 3'b100, 3'b100, 3'b001);
      push_exp(3'b100, 3'b100, 3'b001);
      cfg_we = 1'b1;
      cfg_idx = 3'd1;
      cfg_code = 3'b010;
      sym(3'b100);
      sym(3'b100);
      cfg_we = 1'b0;
      sym(3'b001);
      lamp_valid = 1'b0;
      pop_check("cfg_during_entry");
      attempt("old_code", 3'b001, 3'b010, 3'b100);
      sym(3'b100);
      lamp_valid = 1'b0;
      repeat (31) tick();
      chk("timeout_not_yet", 32'(busy), 1);
      tick();
      chk("timeout_abort", 32'(busy), 0);
      chk("timeout_fail_kept", 32'(fail_count), 1);
      attempt("after_timeout", 3'b100, 3'b100, 3'b001);
      attempt("rst1", 3'b001, 3'b010, 3'b100);
      attempt("rst2", 3'b001, 3'b010, 3'b100);
      attempt("rst3", 3'b001, 3'b010, 3'b100);
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      reset_n = 1'b1;
      model_reset();
      tick();
      attempt("default_restored", 3'b001, 3'b010, 3'b100);
      attempt("prog_code_gone", 3'b100, 3'b100, 3'b001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
